// File: rtl/alert_handler_class_pkg.sv
// Shared constants for the alert classifier/accumulator: default parameter
// values and the helper that derives the class index width from the class count.
package alert_handler_class_pkg;

  localparam int unsigned NAlertsDefault    = 8;
  localparam int unsigned NLocAlertsDefault = 4;
  localparam int unsigned NClassesDefault   = 4;
  localparam int unsigned AccuCntDwDefault  = 16;

  // Minimum width able to encode every class index 0..n_classes-1.
  function automatic int unsigned class_dw(input int unsigned n_classes);
    return (n_classes > 1) ? $clog2(n_classes) : 1;
  endfunction

  localparam int unsigned ClassDwDefault = class_dw(NClassesDefault);

endpackage : alert_handler_class_pkg

// File: rtl/alert_handler_accu_cnt.sv
// One saturating per-class accumulator. A clear beats an increment in the same
// cycle; the threshold pulse is registered alongside the count.
module alert_handler_accu_cnt
  import alert_handler_class_pkg::*;
#(
  parameter int unsigned AccuCntDw = AccuCntDwDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr,
  input  logic                 inc,
  input  logic [AccuCntDw-1:0] thresh,
  output logic [AccuCntDw-1:0] cnt,
  output logic                 trig
);

  logic [AccuCntDw-1:0] cnt_q;
  logic                 trig_q;
  logic [AccuCntDw:0]   cnt_inc;
  logic [AccuCntDw-1:0] cnt_sat;

  // Increment in one extra bit so the carry-out flags saturation instead of wrapping.
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + (AccuCntDw + 1)'(1);
    cnt_sat = cnt_inc[AccuCntDw] ? {AccuCntDw{1'b1}} : cnt_inc[AccuCntDw-1:0];
  end

  // Count register and threshold pulse; clear has priority and drops a same-cycle hit.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement or process ordering.
    if (rst_i) begin
      cnt_q  <= '0;
      trig_q <= 1'b0;
    end else if (clr) begin
      cnt_q  <= '0;
      trig_q <= 1'b0;
    end else if (inc) begin
      cnt_q  <= cnt_sat;
      trig_q <= (cnt_sat >= thresh);
    end else begin
      trig_q <= 1'b0;
    end
  end

  assign cnt  = cnt_q;
  assign trig = trig_q;

endmodule : alert_handler_accu_cnt

// File: rtl/alert_handler_class_accu.sv
// Alert classifier with per-class accumulation. Maps enabled alerts and local
// alerts onto NClasses classes, keeps sticky cause bits, emits registered
// per-class trigger pulses and drives one saturating accumulator per class.
// Optional build macro ALERT_CLASS_IN_REG_EN: registers the trig/en/class
// inputs first, adding one cycle of latency to causes and trigger outputs.
// The clear inputs are never registered.
module alert_handler_class_accu
  import alert_handler_class_pkg::*;
#(
  parameter int unsigned NAlerts    = NAlertsDefault,
  parameter int unsigned NLocAlerts = NLocAlertsDefault,
  parameter int unsigned NClasses   = NClassesDefault,
  parameter int unsigned ClassDw    = class_dw(NClasses),
  parameter int unsigned AccuCntDw  = AccuCntDwDefault
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NAlerts-1:0]                alert_trig_i,
  input  logic [NAlerts-1:0]                alert_en_i,
  input  logic [NAlerts*ClassDw-1:0]        alert_class_i,
  input  logic [NLocAlerts-1:0]             loc_alert_trig_i,
  input  logic [NLocAlerts-1:0]             loc_alert_en_i,
  input  logic [NLocAlerts*ClassDw-1:0]     loc_alert_class_i,
  input  logic [NClasses-1:0]               class_en_i,
  input  logic [NClasses*AccuCntDw-1:0]     accu_thresh_i,
  input  logic [NClasses-1:0]               accu_clr_i,
  input  logic [NAlerts-1:0]                cause_clr_i,
  input  logic [NLocAlerts-1:0]             loc_cause_clr_i,
  output logic [NAlerts-1:0]                alert_cause_o,
  output logic [NLocAlerts-1:0]             loc_alert_cause_o,
  output logic [NClasses-1:0]               class_trig_o,
  output logic [NClasses-1:0]               accu_trig_o,
  output logic [NClasses*AccuCntDw-1:0]     accu_cnt_o
);

  logic [NAlerts-1:0]            alert_trig;
  logic [NAlerts-1:0]            alert_en;
  logic [NAlerts*ClassDw-1:0]    alert_class;
  logic [NLocAlerts-1:0]         loc_trig;
  logic [NLocAlerts-1:0]         loc_en;
  logic [NLocAlerts*ClassDw-1:0] loc_class;

`ifdef ALERT_CLASS_IN_REG_EN
  // Input stage: capture alert events and their configuration one cycle early.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alert_trig  <= '0;
      alert_en    <= '0;
      alert_class <= '0;
      loc_trig    <= '0;
      loc_en      <= '0;
      loc_class   <= '0;
    end else begin
      alert_trig  <= alert_trig_i;
      alert_en    <= alert_en_i;
      alert_class <= alert_class_i;
      loc_trig    <= loc_alert_trig_i;
      loc_en      <= loc_alert_en_i;
      loc_class   <= loc_alert_class_i;
    end
  end
`else
  assign alert_trig  = alert_trig_i;
  assign alert_en    = alert_en_i;
  assign alert_class = alert_class_i;
  assign loc_trig    = loc_alert_trig_i;
  assign loc_en      = loc_alert_en_i;
  assign loc_class   = loc_alert_class_i;
`endif

  logic [NAlerts-1:0]    alert_cause_now;
  logic [NLocAlerts-1:0] loc_cause_now;
  logic [NAlerts-1:0]    alert_cause_q;
  logic [NLocAlerts-1:0] loc_cause_q;
  logic [NClasses-1:0]   hit_any;
  logic [NClasses-1:0]   hit;
  logic [NClasses-1:0]   class_trig_q;

  assign alert_cause_now = alert_en & alert_trig;
  assign loc_cause_now   = loc_en & loc_trig;

  // Sticky cause bits: a new cause in the same cycle overrides the W1C clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alert_cause_q <= '0;
      loc_cause_q   <= '0;
    end else begin
      alert_cause_q <= (alert_cause_q & ~cause_clr_i) | alert_cause_now;
      loc_cause_q   <= (loc_cause_q & ~loc_cause_clr_i) | loc_cause_now;
    end
  end

  // Class hit decode: OR of every active cause whose class index selects class k.
  // Indices at or above NClasses never match a loop value and are dropped.
  always_comb begin
    // NOTE: default assignment first so no path leaves hit_any unassigned (no latch).
    hit_any = '0;
    for (int k = 0; k < NClasses; k++) begin
      for (int i = 0; i < NAlerts; i++) begin
        if (alert_cause_now[i] && (alert_class[i*ClassDw +: ClassDw] == ClassDw'(k))) begin
          hit_any[k] = 1'b1;
        end
      end
      for (int j = 0; j < NLocAlerts; j++) begin
        if (loc_cause_now[j] && (loc_class[j*ClassDw +: ClassDw] == ClassDw'(k))) begin
          hit_any[k] = 1'b1;
        end
      end
    end
  end

  assign hit = hit_any & class_en_i;

  // Registered per-class trigger pulse, one per hit cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      class_trig_q <= '0;
    end else begin
      class_trig_q <= hit;
    end
  end

  for (genvar g = 0; g < NClasses; g++) begin : gen_accu
    alert_handler_accu_cnt #(
      .AccuCntDw (AccuCntDw)
    ) u_accu_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr    (accu_clr_i[g]),
      .inc    (hit[g]),
      .thresh (accu_thresh_i[g*AccuCntDw +: AccuCntDw]),
      .cnt    (accu_cnt_o[g*AccuCntDw +: AccuCntDw]),
      .trig   (accu_trig_o[g])
    );
  end

  assign alert_cause_o     = alert_cause_q;
  assign loc_alert_cause_o = loc_cause_q;
  assign class_trig_o      = class_trig_q;

endmodule : alert_handler_class_accu

// File: tb/tb_alert_handler_class_accu.sv
// Bench for alert_handler_class_accu. A reference model predicts the main
// instance's outputs each cycle into a queue that a negedge monitor drains;
// scenario tasks add directed checks, including a 4-bit accumulator instance
// and a 3-class instance.
module tb_alert_handler_class_accu;

`ifdef ALERT_CLASS_IN_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  typedef struct {
    logic [7:0]  cause;
    logic [3:0]  loc_cause;
    logic [3:0]  ctrig;
    logic [3:0]  atrig;
    logic [63:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [7:0]  alert_trig = '0, alert_en = '0, cause_clr = '0;
  logic [15:0] alert_class = '0;
  logic [3:0]  loc_trig = '0, loc_en = '0, loc_cause_clr = '0;
  logic [7:0]  loc_class = '0;
  logic [3:0]  class_en = '0, accu_clr = '0;
  logic [63:0] thresh = '0;
  logic [15:0] thresh4 = '0;
  logic [47:0] thresh3 = '0;

  logic [7:0]  cause, cause4, cause3;
  logic [3:0]  loc_cause, loc_cause4, loc_cause3;
  logic [3:0]  class_trig, accu_trig, class_trig4, accu_trig4;
  logic [2:0]  class_trig3, accu_trig3;
  logic [63:0] accu_cnt;
  logic [15:0] accu_cnt4;
  logic [47:0] accu_cnt3;

  alert_handler_class_accu dut (
    .clk_i(clk), .rst_i(rst),
    .alert_trig_i(alert_trig), .alert_en_i(alert_en), .alert_class_i(alert_class),
    .loc_alert_trig_i(loc_trig), .loc_alert_en_i(loc_en), .loc_alert_class_i(loc_class),
    .class_en_i(class_en), .accu_thresh_i(thresh), .accu_clr_i(accu_clr),
    .cause_clr_i(cause_clr), .loc_cause_clr_i(loc_cause_clr),
    .alert_cause_o(cause), .loc_alert_cause_o(loc_cause),
    .class_trig_o(class_trig), .accu_trig_o(accu_trig), .accu_cnt_o(accu_cnt)
  );

  alert_handler_class_accu #(.AccuCntDw(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .alert_trig_i(alert_trig), .alert_en_i(alert_en), .alert_class_i(alert_class),
    .loc_alert_trig_i(loc_trig), .loc_alert_en_i(loc_en), .loc_alert_class_i(loc_class),
    .class_en_i(class_en), .accu_thresh_i(thresh4), .accu_clr_i(accu_clr),
    .cause_clr_i(cause_clr), .loc_cause_clr_i(loc_cause_clr),
    .alert_cause_o(cause4), .loc_alert_cause_o(loc_cause4),
    .class_trig_o(class_trig4), .accu_trig_o(accu_trig4), .accu_cnt_o(accu_cnt4)
  );

  alert_handler_class_accu #(.NClasses(3), .ClassDw(2)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .alert_trig_i(alert_trig), .alert_en_i(alert_en), .alert_class_i(alert_class),
    .loc_alert_trig_i(loc_trig), .loc_alert_en_i(loc_en), .loc_alert_class_i(loc_class),
    .class_en_i(class_en[2:0]), .accu_thresh_i(thresh3), .accu_clr_i(accu_clr[2:0]),
    .cause_clr_i(cause_clr), .loc_cause_clr_i(loc_cause_clr),
    .alert_cause_o(cause3), .loc_alert_cause_o(loc_cause3),
    .class_trig_o(class_trig3), .accu_trig_o(accu_trig3), .accu_cnt_o(accu_cnt3)
  );

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model state for the main instance.
  logic [7:0]  m_cause = '0;
  logic [3:0]  m_loc_cause = '0;
  int          m_cnt[4] = '{0, 0, 0, 0};
  logic [7:0]  p_trig = '0, p_en = '0;
  logic [15:0] p_class = '0;
  logic [3:0]  p_ltrig = '0, p_len = '0;
  logic [7:0]  p_lclass = '0;

  // Predict the outputs the coming edge produces, queue them, then advance one cycle.
  task automatic tick();
    exp_t e;
    logic [7:0] etrig, een, now;
    logic [15:0] ecls;
    logic [3:0] eltrig, elen, lnow, hit;
    logic [7:0] elcls;
    e.cause = '0; e.loc_cause = '0; e.ctrig = '0; e.atrig = '0; e.cnt = '0;
    if (rst) begin
      m_cause = '0; m_loc_cause = '0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      p_trig = '0; p_en = '0; p_class = '0; p_ltrig = '0; p_len = '0; p_lclass = '0;
    end else begin
      if (Lat == 2) begin
        etrig = p_trig; een = p_en; ecls = p_class; eltrig = p_ltrig; elen = p_len; elcls = p_lclass;
        p_trig = alert_trig; p_en = alert_en; p_class = alert_class;
        p_ltrig = loc_trig; p_len = loc_en; p_lclass = loc_class;
      end else begin
        etrig = alert_trig; een = alert_en; ecls = alert_class;
        eltrig = loc_trig; elen = loc_en; elcls = loc_class;
      end
      now  = etrig & een;
      lnow = eltrig & elen;
      m_cause     = (m_cause & ~cause_clr) | now;
      m_loc_cause = (m_loc_cause & ~loc_cause_clr) | lnow;
      hit = '0;
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 8; i++) if (now[i] && int'(ecls[i*2 +: 2]) == k) hit[k] = 1'b1;
        for (int j = 0; j < 4; j++) if (lnow[j] && int'(elcls[j*2 +: 2]) == k) hit[k] = 1'b1;
      end
      hit = hit & class_en;
      for (int k = 0; k < 4; k++) begin
        if (accu_clr[k]) begin
          m_cnt[k] = 0;
        end else if (hit[k]) begin
          m_cnt[k] = (m_cnt[k] < 65535) ? m_cnt[k] + 1 : 65535;
          e.atrig[k] = (m_cnt[k] >= int'(thresh[k*16 +: 16]));
        end
        e.cnt[k*16 +: 16] = 16'(m_cnt[k]);
      end
      e.cause = m_cause; e.loc_cause = m_loc_cause; e.ctrig = hit;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare the main instance against the queued prediction.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_cmp++;
      if (cause !== mon_e.cause) begin
        n_err++; $display("FAIL sb_alert_cause t=%0t got=%b exp=%b", $time, cause, mon_e.cause);
      end
      n_cmp++;
      if (loc_cause !== mon_e.loc_cause) begin
        n_err++; $display("FAIL sb_loc_cause t=%0t got=%b exp=%b", $time, loc_cause, mon_e.loc_cause);
      end
      n_cmp++;
      if (class_trig !== mon_e.ctrig) begin
        n_err++; $display("FAIL sb_class_trig t=%0t got=%b exp=%b", $time, class_trig, mon_e.ctrig);
      end
      n_cmp++;
      if (accu_trig !== mon_e.atrig) begin
        n_err++; $display("FAIL sb_accu_trig t=%0t got=%b exp=%b", $time, accu_trig, mon_e.atrig);
      end
      n_cmp++;
      if (accu_cnt !== mon_e.cnt) begin
        n_err++; $display("FAIL sb_accu_cnt t=%0t got=%h exp=%h", $time, accu_cnt, mon_e.cnt);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    thresh = {16'd100, 16'd100, 16'd100, 16'd100};
    thresh4 = {4'd15, 4'd15, 4'd15, 4'd5};
    thresh3 = {16'd2, 16'd2, 16'd2};
    tick();
    tick();
    n_cmp++;
    if ({cause, loc_cause, class_trig, accu_trig, accu_cnt} !== '0) begin
      n_err++; $display("FAIL reset_main got=%h exp=0", {cause, loc_cause, class_trig, accu_trig, accu_cnt});
    end
    n_cmp++;
    if ({cause4, class_trig4, accu_trig4, accu_cnt4} !== '0) begin
      n_err++; $display("FAIL reset_dut4 got=%h exp=0", {cause4, class_trig4, accu_trig4, accu_cnt4});
    end
    n_cmp++;
    if ({cause3, class_trig3, accu_trig3, accu_cnt3} !== '0) begin
      n_err++; $display("FAIL reset_dut3 got=%h exp=0", {cause3, class_trig3, accu_trig3, accu_cnt3});
    end
    rst = 1'b0;
    class_en = 4'hF;
    tick();
  endtask

  task automatic test_single_alert();
    alert_en[3] = 1'b1;
    alert_class[6 +: 2] = 2'd2;
    alert_trig[3] = 1'b1;
    tick();
    alert_trig = '0;
    repeat (Lat - 1) tick();
    n_cmp++;
    if (class_trig !== 4'b0100) begin
      n_err++; $display("FAIL t1_class_trig got=%b exp=0100", class_trig);
    end
    n_cmp++;
    if (cause[3] !== 1'b1) begin
      n_err++; $display("FAIL t1_cause_set got=%b exp=1", cause[3]);
    end
    tick();
    n_cmp++;
    if (class_trig !== 4'b0000 || cause[3] !== 1'b1) begin
      n_err++; $display("FAIL t1_pulse_once trig=%b cause=%b exp trig=0000 cause=1", class_trig, cause[3]);
    end
    cause_clr[3] = 1'b1;
    tick();
    cause_clr = '0;
    n_cmp++;
    if (cause[3] !== 1'b0) begin
      n_err++; $display("FAIL t1_cause_clr got=%b exp=0", cause[3]);
    end
  endtask

  task automatic test_threshold();
    accu_clr = 4'hF;
    tick();
    accu_clr = '0;
    alert_en[0] = 1'b1;
    alert_class[0 +: 2] = 2'd1;
    thresh[16 +: 16] = 16'd3;
    for (int h = 1; h <= 3; h++) begin
      alert_trig[0] = 1'b1;
      tick();
      alert_trig = '0;
      repeat (Lat - 1) tick();
      n_cmp++;
      if (accu_cnt[16 +: 16] !== 16'(h) || accu_trig[1] !== (h == 3)) begin
        n_err++;
        $display("FAIL t2_hit%0d cnt=%0d trig=%b exp cnt=%0d trig=%b", h, accu_cnt[16 +: 16], accu_trig[1], h, h == 3);
      end
      tick();
    end
  endtask

  task automatic test_same_cycle_merge();
    accu_clr = 4'hF;
    tick();
    accu_clr = '0;
    alert_en = alert_en | 8'b0010_0011;
    alert_class[0 +: 2] = 2'd0;
    alert_class[2 +: 2] = 2'd0;
    alert_class[10 +: 2] = 2'd0;
    loc_en[2] = 1'b1;
    loc_class[4 +: 2] = 2'd3;
    alert_trig = 8'b0010_0011;
    loc_trig[2] = 1'b1;
    tick();
    alert_trig = '0;
    loc_trig = '0;
    repeat (Lat - 1) tick();
    n_cmp++;
    if (class_trig !== 4'b1001 || accu_cnt[0 +: 16] !== 16'd1) begin
      n_err++; $display("FAIL t3_merge trig=%b cnt0=%0d exp trig=1001 cnt0=1", class_trig, accu_cnt[0 +: 16]);
    end
    n_cmp++;
    if (cause !== 8'b0010_0011 || loc_cause !== 4'b0100) begin
      n_err++; $display("FAIL t3_causes cause=%b loc=%b exp cause=00100011 loc=0100", cause, loc_cause);
    end
    tick();
    n_cmp++;
    if (class_trig !== 4'b0000) begin
      n_err++; $display("FAIL t3_single_pulse got=%b exp=0000", class_trig);
    end
  endtask

  task automatic test_saturation();
    int sat;
    accu_clr = 4'hF;
    tick();
    accu_clr = '0;
    thresh[0 +: 16] = 16'd4;
    for (int h = 1; h <= 20; h++) begin
      alert_trig[0] = 1'b1;
      tick();
      alert_trig = '0;
      repeat (Lat - 1) tick();
      sat = (h > 15) ? 15 : h;
      n_cmp++;
      if (accu_cnt4[3:0] !== 4'(sat) || accu_trig4[0] !== (sat >= 5)) begin
        n_err++;
        $display("FAIL t4_sat_hit%0d cnt=%0d trig=%b exp cnt=%0d trig=%b", h, accu_cnt4[3:0], accu_trig4[0], sat, sat >= 5);
      end
    end
  endtask

  task automatic test_clear_priority();
    accu_clr = 4'hF;
    tick();
    accu_clr = '0;
    thresh[32 +: 16] = 16'd0;
    alert_trig[3] = 1'b1;
    tick();
    alert_trig = '0;
    repeat (Lat - 1) tick();
    n_cmp++;
    if (accu_cnt[32 +: 16] !== 16'd1 || accu_trig[2] !== 1'b1) begin
      n_err++; $display("FAIL t5_thresh0 cnt=%0d trig=%b exp cnt=1 trig=1", accu_cnt[32 +: 16], accu_trig[2]);
    end
    alert_trig[3] = 1'b1;
    if (Lat == 2) begin
      tick();
      alert_trig = '0;
    end
    accu_clr[2] = 1'b1;
    cause_clr[3] = 1'b1;
    tick();
    alert_trig = '0;
    accu_clr = '0;
    cause_clr = '0;
    n_cmp++;
    if (accu_cnt[32 +: 16] !== 16'd0 || accu_trig[2] !== 1'b0 || class_trig[2] !== 1'b1) begin
      n_err++;
      $display("FAIL t5_clr_vs_hit cnt=%0d atrig=%b ctrig=%b exp cnt=0 atrig=0 ctrig=1", accu_cnt[32 +: 16], accu_trig[2], class_trig[2]);
    end
    n_cmp++;
    if (cause[3] !== 1'b1) begin
      n_err++; $display("FAIL t5_set_wins got=%b exp=1", cause[3]);
    end
  endtask

  task automatic test_bad_class_and_reset();
    accu_clr = 4'hF;
    tick();
    accu_clr = '0;
    alert_en[6] = 1'b1;
    alert_class[12 +: 2] = 2'd3;
    alert_trig[6] = 1'b1;
    tick();
    alert_trig = '0;
    repeat (Lat - 1) tick();
    n_cmp++;
    if (class_trig3 !== 3'b000 || accu_trig3 !== 3'b000 || accu_cnt3 !== '0) begin
      n_err++; $display("FAIL t6_bad_class trig=%b atrig=%b cnt=%h exp all 0", class_trig3, accu_trig3, accu_cnt3);
    end
    n_cmp++;
    if (class_trig !== 4'b1000 || cause3[6] !== 1'b1) begin
      n_err++; $display("FAIL t6_class3_main trig=%b cause3_6=%b exp trig=1000 cause=1", class_trig, cause3[6]);
    end
    alert_trig[0] = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (accu_cnt3[0 +: 16] !== 16'(3 - Lat)) begin
      n_err++; $display("FAIL t6_accum got=%0d exp=%0d", accu_cnt3[0 +: 16], 3 - Lat);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({cause, loc_cause, class_trig, accu_trig, accu_cnt} !== '0) begin
      n_err++; $display("FAIL t6_reset_main got=%h exp=0", {cause, loc_cause, class_trig, accu_trig, accu_cnt});
    end
    n_cmp++;
    if ({cause3, loc_cause3, class_trig3, accu_trig3, accu_cnt3} !== '0) begin
      n_err++; $display("FAIL t6_reset_dut3 got=%h exp=0", {cause3, loc_cause3, class_trig3, accu_trig3, accu_cnt3});
    end
    rst = 1'b0;
    alert_trig = '0;
    tick();
    tick();
    n_cmp++;
    if (class_trig !== 4'b0000 || accu_trig !== 4'b0000) begin
      n_err++; $display("FAIL t6_no_ghost trig=%b atrig=%b exp 0000 0000", class_trig, accu_trig);
    end
  endtask

  initial begin
    test_reset();
    test_single_alert();
    test_threshold();
    test_same_cycle_merge();
    test_saturation();
    test_clear_priority();
    test_bad_class_and_reset();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alert_handler_class_accu
